// File: rtl/div_pool_scheduler.sv
// div_pool_scheduler: round-robin dispatch of tagged entries to a divider pool, result arbitration onto one port (`DIV_IN_ORDER_EN` = dispatch-order output).
// Latency: div_valid -> out_valid 1 cycle, start/ack combinational; out_sel/out_tag frozen while out_ready is low.

`ifdef DIV_IN_ORDER_EN
module sync_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic         empty
);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return ({1'b0, p} == CNW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_vld) begin
        mem_q[wr_q] <= push_dat;
        wr_q        <= wrap_inc(wr_q);
      end
      if (pop_vld) rd_q <= wrap_inc(rd_q);
      case ({push_vld, pop_vld})
        2'b10:   cnt_q <= cnt_q + CNW'(1);
        2'b01:   cnt_q <= cnt_q - CNW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_dat = mem_q[rd_q];
  assign empty    = (cnt_q == '0);
endmodule
`endif

module div_pool_scheduler #(
  parameter int DIV_COUNT = 16,
  parameter int TAG_BITS  = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [TAG_BITS-1:0]          in_tag,
  output logic                         in_ready,
  input  logic [DIV_COUNT-1:0]         div_ready,
  output logic [DIV_COUNT-1:0]         div_start,
  input  logic [DIV_COUNT-1:0]         div_valid,
  output logic [DIV_COUNT-1:0]         div_ack,
  output logic                         out_valid,
  output logic [$clog2(DIV_COUNT)-1:0] out_sel,
  output logic [TAG_BITS-1:0]          out_tag,
  input  logic                         out_ready,
  output logic [$clog2(DIV_COUNT):0]   busy_count,
  output logic                         err
);
  localparam int IW = $clog2(DIV_COUNT);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} slot_st_e;

  slot_st_e            state_q [DIV_COUNT];
  slot_st_e            state_d [DIV_COUNT];
  logic [TAG_BITS-1:0] tag_tbl_q [DIV_COUNT];
  logic [IW-1:0]       disp_ptr_q;
  logic [CW-1:0]       busy_q;
  logic                err_q;

  logic [DIV_COUNT-1:0] idle_m, busy_m, done_m, eligible;
  logic [IW:0]          disp_pick;
  logic [IW-1:0]        disp_idx, sel;
  logic                 dispatch, hs;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return ({1'b0, v} == CW'(DIV_COUNT - 1)) ? '0 : v + IW'(1);
  endfunction

  // Returns {found, index} of the first request at or after ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [DIV_COUNT-1:0] req, input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] idx;
    logic [CW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < DIV_COUNT; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(DIV_COUNT)) cand = cand - CW'(DIV_COUNT);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    idle_m = '0;
    busy_m = '0;
    done_m = '0;
    for (int i = 0; i < DIV_COUNT; i++) begin
      idle_m[i] = (state_q[i] == S_IDLE);
      busy_m[i] = (state_q[i] == S_BUSY);
      done_m[i] = (state_q[i] == S_DONE);
    end
  end

  assign eligible  = idle_m & div_ready;
  assign disp_pick = rr_pick(eligible, disp_ptr_q);
  assign disp_idx  = disp_pick[IW-1:0];
  assign in_ready  = reset & disp_pick[IW];
  assign dispatch  = in_valid & in_ready;
  assign hs        = out_valid & out_ready;

`ifdef DIV_IN_ORDER_EN
  logic [IW-1:0] head_idx;
  logic          fifo_empty;

  sync_fifo #(.W(IW), .DEPTH(DIV_COUNT)) u_idx_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_vld (dispatch),
    .push_dat (disp_idx),
    .pop_vld  (hs),
    .head_dat (head_idx),
    .empty    (fifo_empty)
  );

  assign sel       = head_idx;
  assign out_valid = reset & ~fifo_empty & done_m[head_idx];
`else
  logic [IW-1:0] out_ptr_q, held_sel_q;
  logic          held_vld_q;
  logic [IW:0]   out_pick;

  assign out_pick  = rr_pick(done_m, out_ptr_q);
  // A stalled grant is frozen so late completions cannot steal the port.
  assign sel       = held_vld_q ? held_sel_q : out_pick[IW-1:0];
  assign out_valid = reset & out_pick[IW];

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_ptr_q  <= '0;
      held_sel_q <= '0;
      held_vld_q <= 1'b0;
    end else begin
      held_vld_q <= out_valid & ~out_ready;
      held_sel_q <= sel;
      if (hs) out_ptr_q <= inc_wrap(sel);
    end
  end
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < DIV_COUNT; i++) begin
      state_q[i] <= reset ? state_d[i] : S_IDLE;
    end
  end

  always_comb begin
    for (int i = 0; i < DIV_COUNT; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE:  if (dispatch && disp_idx == IW'(i)) state_d[i] = S_BUSY;
        S_BUSY:  if (div_valid[i]) state_d[i] = S_DONE;
        S_DONE:  if (hs && sel == IW'(i)) state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    div_start = '0;
    div_ack   = '0;
    if (dispatch) div_start[disp_idx] = 1'b1;
    if (hs)       div_ack[sel]        = 1'b1;
    out_sel = out_valid ? sel : '0;
    out_tag = out_valid ? tag_tbl_q[sel] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DIV_COUNT; i++) tag_tbl_q[i] <= '0;
      disp_ptr_q <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (dispatch) begin
        tag_tbl_q[disp_idx] <= in_tag;
        disp_ptr_q          <= inc_wrap(disp_idx);
      end
      case ({dispatch, hs})
        2'b10:   busy_q <= busy_q + CW'(1);
        2'b01:   busy_q <= busy_q - CW'(1);
        default: busy_q <= busy_q;
      endcase
      err_q <= err_q | (|(div_valid & ~busy_m));
    end
  end

  assign busy_count = busy_q;
  assign err        = err_q;
endmodule

// File: tb/tb_div_pool_scheduler.sv
// Directed bench for div_pool_scheduler (DIV_COUNT=4): stimulus pushes expected results, a negedge monitor checks every output handshake.
module tb_div_pool_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [5:0] in_tag;
  logic       in_ready;
  logic [3:0] div_ready, div_start, div_valid, div_ack;
  logic       out_valid;
  logic [1:0] out_sel;
  logic [5:0] out_tag;
  logic       out_ready;
  logic [2:0] busy_count;
  logic       err;

  typedef struct {
    logic [1:0] sel;
    logic [5:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  div_pool_scheduler #(.DIV_COUNT(4), .TAG_BITS(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_tag     (in_tag),
    .in_ready   (in_ready),
    .div_ready  (div_ready),
    .div_start  (div_start),
    .div_valid  (div_valid),
    .div_ack    (div_ack),
    .out_valid  (out_valid),
    .out_sel    (out_sel),
    .out_tag    (out_tag),
    .out_ready  (out_ready),
    .busy_count (busy_count),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] s, input logic [5:0] t);
    exp_t e;
    e.sel = s;
    e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got sel=%0d tag=%0d expected none", out_sel, out_tag);
      end else begin
        e = exp_q.pop_front();
        chk("out_sel", 32'(out_sel), 32'(e.sel));
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        chk("div_ack_hs", 32'(div_ack), 32'(1) << e.sel);
      end
    end else begin
      chk("div_ack_idle", 32'(div_ack), 32'd0);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 6'd3;
    div_ready = 4'b1111;
    div_valid = 4'b0000;
    out_ready = 1'b1;

    // reset held with a valid entry pending
    repeat (3) begin
      next_cycle();
      @(negedge clk);
      chk("rst_div_start", 32'(div_start), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy_count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
    end
    next_cycle();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_sel", 32'(out_sel), 32'd0);
    chk("post_rst_out_tag", 32'(out_tag), 32'd0);

    // dispatch rotation, tags 5..8
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      in_valid = 1'b1;
      in_tag   = 6'(5 + i);
      @(negedge clk);
      chk("disp_start", 32'(div_start), 32'(1) << i);
    end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_busy", 32'(busy_count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);

    // out-of-order completion of slots 2 and 0
    next_cycle();
    div_valid = 4'b0101;
    push_exp(2'd0, 6'd5);
    push_exp(2'd2, 6'd7);
    @(negedge clk);
    chk("ooo_latency", 32'(out_valid), 32'd0);
    next_cycle();
    div_valid = 4'b0000;
    @(negedge clk);
    chk("ooo_valid", 32'(out_valid), 32'd1);
    next_cycle();
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk("ooo_drained", 32'(out_valid), 32'd0);
    chk("ooo_busy", 32'(busy_count), 32'd2);

    // backpressure on slot 1; slot 3 completes mid-stall and must not steal the port
    next_cycle();
    out_ready = 1'b0;
    div_valid = 4'b0010;
    push_exp(2'd1, 6'd6);
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      next_cycle();
      div_valid = (s == 1) ? 4'b1000 : 4'b0000;
      if (s == 1) push_exp(2'd3, 6'd8);
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sel", 32'(out_sel), 32'd1);
      chk("bp_tag", 32'(out_tag), 32'd6);
      chk("bp_no_ack", 32'(div_ack), 32'd0);
    end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ack", 32'(div_ack), 32'b0010);

    // free and refill slot 3
    next_cycle();
    in_valid  = 1'b1;
    in_tag    = 6'd9;
    div_ready = 4'b1000;
    @(negedge clk);
    chk("refill_no_start", 32'(div_start), 32'd0);
    chk("refill_in_ready", 32'(in_ready), 32'd0);
    chk("refill_busy_n", 32'(busy_count), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("refill_start", 32'(div_start), 32'b1000);
    chk("refill_busy_n1", 32'(busy_count), 32'd0);
    next_cycle();
    in_valid  = 1'b0;
    div_ready = 4'b1111;
    div_valid = 4'b1000;
    push_exp(2'd3, 6'd9);
    @(negedge clk);
    chk("refill_busy_n2", 32'(busy_count), 32'd1);

    // dispatch to slot 0 in the same cycle slot 3 is acked
    next_cycle();
    div_valid = 4'b0000;
    in_valid  = 1'b1;
    in_tag    = 6'd10;
    div_ready = 4'b0001;
    @(negedge clk);
    chk("both_start", 32'(div_start), 32'b0001);
    chk("both_out_valid", 32'(out_valid), 32'd1);
    chk("both_busy_before", 32'(busy_count), 32'd1);

    // spurious completion on idle slot 2
    next_cycle();
    in_valid  = 1'b0;
    div_ready = 4'b1111;
    div_valid = 4'b0100;
    @(negedge clk);
    chk("both_busy_after", 32'(busy_count), 32'd1);
    chk("err_not_yet", 32'(err), 32'd0);
    next_cycle();
    div_valid = 4'b0000;
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    chk("err_busy", 32'(busy_count), 32'd1);
    chk("err_out_valid", 32'(out_valid), 32'd0);
    next_cycle();
    div_valid = 4'b0001;
    push_exp(2'd0, 6'd10);
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    next_cycle();
    div_valid = 4'b0000;
    @(negedge clk);
    chk("final_valid", 32'(out_valid), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("final_busy", 32'(busy_count), 32'd0);
    chk("final_err", 32'(err), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
